// File: rtl/rotor_stepper_if.sv
// rotor_stepper_if
// Groups the key-load, upstream character, downstream output and count
// signals of rotor_stepper so they travel as one bundle.
//   master : the side that loads keys, supplies characters and consumes output
//   slave  : rotor_stepper itself
// Signals:
//   load, init_pos1..3      key load request and initial rotor positions
//   char_valid, char_in     upstream character offer (0..25 = A..Z)
//   char_ready              rotor_stepper can take a character this cycle
//   out_valid, out_char     stepped character presented downstream
//   pos1..pos3              current rotor positions (fast rotor is pos1)
//   out_ready               downstream has consumed the output
//   char_count              characters completed since reset or load
interface rotor_stepper_if;
    logic        load;
    logic [4:0]  init_pos1;
    logic [4:0]  init_pos2;
    logic [4:0]  init_pos3;
    logic        char_valid;
    logic [4:0]  char_in;
    logic        char_ready;
    logic        out_valid;
    logic [4:0]  out_char;
    logic [4:0]  pos1;
    logic [4:0]  pos2;
    logic [4:0]  pos3;
    logic        out_ready;
    logic [15:0] char_count;

    modport master (
        output load, init_pos1, init_pos2, init_pos3, char_valid, char_in, out_ready,
        input  char_ready, out_valid, out_char, pos1, pos2, pos3, char_count
    );

    modport slave (
        input  load, init_pos1, init_pos2, init_pos3, char_valid, char_in, out_ready,
        output char_ready, out_valid, out_char, pos1, pos2, pos3, char_count
    );
endinterface

// File: rtl/rotor_stepper.sv
// rotor_stepper
// Rotor position controller for the ENIGMA551 datapath. Each accepted
// character advances the three rotors with the Enigma odometer rule
// (including the middle-rotor double-step), then the character is presented
// together with the post-step positions until downstream consumes it.
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous, active-high reset
//   bus   rotor_stepper_if slave modport (load / character / output / count)
// Parameters:
//   NOTCH_R1  fast-rotor position from which the middle rotor is carried
//   NOTCH_R2  middle-rotor position causing the slow-rotor carry and double-step
module rotor_stepper #(
    parameter int NOTCH_R1 = 16,
    parameter int NOTCH_R2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    rotor_stepper_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [4:0] NOTCH1_C = 5'(NOTCH_R1);
    localparam logic [4:0] NOTCH2_C = 5'(NOTCH_R2);

    // Fold a 5-bit load value into 0..25 (26..31 map to 0..5).
    function automatic logic [4:0] fold26(input logic [4:0] v);
        logic [4:0] r;
        if (v >= 5'd26) begin
            r = v - 5'd26;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Advance one rotor position modulo 26.
    function automatic logic [4:0] inc26(input logic [4:0] v);
        logic [4:0] r;
        if (v == 5'd25) begin
            r = 5'd0;
        end else begin
            r = v + 5'd1;
        end
        return r;
    endfunction

    logic [1:0]  state_r;
    logic [4:0]  pos1_r;
    logic [4:0]  pos2_r;
    logic [4:0]  pos3_r;
    logic [4:0]  out_char_r;
    logic        out_valid_r;
    logic [15:0] char_count_r;

    logic        d2_s;
    logic        c1_s;
    logic [4:0]  pos1_step_s;
    logic [4:0]  pos2_step_s;
    logic [4:0]  pos3_step_s;

    // Post-step positions; notch tests use the pre-step values so the middle
    // rotor moves at most once even when both carries coincide.
    always_comb begin
        d2_s        = (pos2_r == NOTCH2_C);
        c1_s        = (pos1_r == NOTCH1_C);
        pos1_step_s = inc26(pos1_r);
        if (d2_s || c1_s) begin
            pos2_step_s = inc26(pos2_r);
        end else begin
            pos2_step_s = pos2_r;
        end
        if (d2_s) begin
            pos3_step_s = inc26(pos3_r);
        end else begin
            pos3_step_s = pos3_r;
        end
    end

    // Controller FSM with positions, output character and character counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pos1_r       <= 5'd0;
            pos2_r       <= 5'd0;
            pos3_r       <= 5'd0;
            out_char_r   <= 5'd0;
            out_valid_r  <= 1'b0;
            char_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // load wins over a simultaneous character offer
                    if (bus.load) begin
                        pos1_r       <= fold26(bus.init_pos1);
                        pos2_r       <= fold26(bus.init_pos2);
                        pos3_r       <= fold26(bus.init_pos3);
                        char_count_r <= 16'd0;
                    end else if (bus.char_valid) begin
                        out_char_r <= bus.char_in;
                        state_r    <= ST_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STEP: begin
                    pos1_r       <= pos1_step_s;
                    pos2_r       <= pos2_step_s;
                    pos3_r       <= pos3_step_s;
                    char_count_r <= char_count_r + 16'd1;
                    out_valid_r  <= 1'b1;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // char_ready is deliberately combinational so a load in IDLE blocks
    // acceptance within the same cycle.
    assign bus.char_ready = (state_r == ST_IDLE) && !bus.load;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_char   = out_char_r;
    assign bus.pos1       = pos1_r;
    assign bus.pos2       = pos2_r;
    assign bus.pos3       = pos3_r;
    assign bus.char_count = char_count_r;

endmodule

// File: tb/tb_rotor_stepper.sv
// tb_rotor_stepper
// Directed self-checking bench for rotor_stepper. A behavioural model tracks
// rotor positions as integers with mod-26 arithmetic; a compare process checks
// every DUT output against it on each falling edge, and hand-computed literal
// expectations pin both the model and the DUT at key points.
module tb_rotor_stepper;

    logic clk;
    logic rst;
    rotor_stepper_if bus ();

    rotor_stepper #(.NOTCH_R1(16), .NOTCH_R2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model state: phase 0 = waiting for a character, 1 = stepping, 2 = presenting
    int m_p1, m_p2, m_p3, m_cnt, m_char, m_phase;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fold(input int v);
        return (v >= 26) ? v - 26 : v;
    endfunction

    // Behavioural model of the stepping rule and handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p1 = 0; m_p2 = 0; m_p3 = 0; m_cnt = 0; m_char = 0; m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (bus.load) begin
                    m_p1 = fold(int'(bus.init_pos1));
                    m_p2 = fold(int'(bus.init_pos2));
                    m_p3 = fold(int'(bus.init_pos3));
                    m_cnt = 0;
                end else if (bus.char_valid) begin
                    m_char = int'(bus.char_in);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                bit dbl, carry;
                dbl   = (m_p2 == 4);
                carry = (m_p1 == 16);
                m_p1 = (m_p1 + 1) % 26;
                if (dbl || carry) m_p2 = (m_p2 + 1) % 26;
                if (dbl) m_p3 = (m_p3 + 1) % 26;
                m_cnt = (m_cnt + 1) % 65536;
                m_phase = 2;
            end else begin
                if (bus.out_ready) m_phase = 0;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("char_ready", int'(bus.char_ready), int'(m_phase == 0 && !bus.load));
            check("out_valid", int'(bus.out_valid), int'(m_phase == 2));
            check("out_char", int'(bus.out_char), m_char);
            check("pos1", int'(bus.pos1), m_p1);
            check("pos2", int'(bus.pos2), m_p2);
            check("pos3", int'(bus.pos3), m_p3);
            check("char_count", int'(bus.char_count), m_cnt);
        end
    end

    // Pin DUT and model positions to hand-computed values (pos3, pos2, pos1).
    task automatic check_pos(input string name, input int p3, input int p2, input int p1);
        check({name, "_dut_p3"}, int'(bus.pos3), p3);
        check({name, "_dut_p2"}, int'(bus.pos2), p2);
        check({name, "_dut_p1"}, int'(bus.pos1), p1);
        check({name, "_mdl_p3"}, m_p3, p3);
        check({name, "_mdl_p2"}, m_p2, p2);
        check({name, "_mdl_p1"}, m_p1, p1);
    endtask

    // All driving tasks start and end just after a rising edge.
    task automatic do_load(input int p3, input int p2, input int p1);
        bus.load = 1'b1;
        bus.init_pos3 = 5'(p3);
        bus.init_pos2 = 5'(p2);
        bus.init_pos1 = 5'(p1);
        @(posedge clk); #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout", int'(bus.out_valid), 1);
    endtask

    task automatic send(input int c);
        bus.char_valid = 1'b1;
        bus.char_in = 5'(c);
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        check("step_cycle_no_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("valid_second_edge", int'(bus.out_valid), 1);
        wait_valid();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    int held_p1;

    initial begin
        bus.load = 1'b0;
        bus.init_pos1 = 5'd0;
        bus.init_pos2 = 5'd0;
        bus.init_pos3 = 5'd0;
        bus.char_valid = 1'b0;
        bus.char_in = 5'd0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // reset state
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_char_ready", int'(bus.char_ready), 1);
        check_pos("rst", 0, 0, 0);

        // load then one character
        do_load(0, 3, 15);
        check_pos("load", 0, 3, 15);
        send(0);
        check_pos("first", 0, 3, 16);
        check("first_out_char", int'(bus.out_char), 0);
        check("first_count", int'(bus.char_count), 1);

        // double-step sequence
        send(1);
        check_pos("ds1", 0, 4, 17);
        send(2);
        check_pos("ds2", 1, 5, 18);
        send(25);
        check_pos("ds3", 1, 5, 19);
        check("ds_count", int'(bus.char_count), 4);
        check("ds_out_char", int'(bus.out_char), 25);

        // wrap cases
        do_load(25, 25, 25);
        send(7);
        check_pos("wrap1", 25, 25, 0);
        do_load(25, 4, 0);
        send(8);
        check_pos("wrap2", 0, 5, 1);

        // simultaneous carry and double-step
        do_load(2, 4, 16);
        send(9);
        check_pos("simul", 3, 5, 17);

        // load range fold
        do_load(0, 0, 30);
        check_pos("fold", 0, 0, 4);
        do_load(31, 26, 27);
        check_pos("fold_all", 5, 0, 1);
        check("fold_count", int'(bus.char_count), 0);

        // stall with char_valid held high
        bus.char_valid = 1'b1;
        bus.char_in = 5'd12;
        @(posedge clk); #1;
        wait_valid();
        held_p1 = int'(bus.pos1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", int'(bus.out_valid), 1);
            check("stall_ready", int'(bus.char_ready), 0);
            check("stall_pos1", int'(bus.pos1), 2);
            check("stall_char", int'(bus.out_char), 12);
        end
        check("stall_held_p1", held_p1, 2);
        bus.char_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // load and char_valid together
        bus.load = 1'b1;
        bus.init_pos3 = 5'd1;
        bus.init_pos2 = 5'd2;
        bus.init_pos1 = 5'd3;
        bus.char_valid = 1'b1;
        bus.char_in = 5'd7;
        #1 check("prio_ready", int'(bus.char_ready), 0);
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.char_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("prio_no_valid", int'(bus.out_valid), 0);
        check("prio_out_char", int'(bus.out_char), 12);
        check_pos("prio", 1, 2, 3);

        // reset asserted mid-HOLD
        bus.char_valid = 1'b1;
        bus.char_in = 5'd20;
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        wait_valid();
        check_pos("pre_rst", 1, 2, 4);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_ready", int'(bus.char_ready), 1);
        check("mid_rst_count", int'(bus.char_count), 0);
        check_pos("mid_rst", 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", int'(bus.out_valid), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Rotor position controller for the ENIGMA551 datapath. It sits directly upstream of the rotor mapping stages. For each accepted plaintext character it advances the three rotor positions using the standard Enigma odometer rule, including the middle-rotor double-step. It then presents the character together with the post-step positions, so the downstream rotors (rotor2_forward included) encrypt with the updated offsets. It also handles loading of the initial key setting and counts processed characters.

## Interface
Parameters:
- NOTCH_R1, default 16 (Q): rotor 1 (fast, rightmost) position from which rotor 2 is carried.
- NOTCH_R2, default 4 (E): rotor 2 position that triggers a rotor 3 carry and a rotor 2 double-step.

Ports:
- clk, in, 1: single system clock, rising-edge.
- rst, in, 1: asynchronous, active-high reset.
- load, in, 1: load initial positions. Sampled only in IDLE.
- init_pos1 / init_pos2 / init_pos3, in, 5 each: initial positions for rotors 1/2/3.
- char_valid, in, 1: upstream character available.
- char_in, in, 5: character, 0..25 = A..Z.
- char_ready, out, 1: equals (state==IDLE) && !load. Combinational.
- out_valid, out, 1: stepped character and positions are valid. Registered.
- out_char, out, 5: latched character.
- pos1 / pos2 / pos3, out, 5 each: current rotor positions, registered. Feed the rotor `position` inputs.
- out_ready, in, 1: downstream consumed the output.
- char_count, out, 16: characters completed since reset or load.

## Operation
- FSM has three states: IDLE, STEP, HOLD.
- **IDLE**
  - If load=1: on the clock edge, pos1..3 take init_pos1..3, char_count clears to 0, and the state stays IDLE.
  - Otherwise, if char_valid=1 (char_ready is then 1): latch char_in into out_char and go to STEP.
  - load has priority. A character presented in the same cycle as load is not accepted.
- **Load value range:** a loaded value v ≥ 26 is stored as v−26. Positions are always held in 0..25.
- **STEP:** apply the stepping rule (below) to all three positions in a single edge, increment char_count (wraps 65535→0), set out_valid=1, and go to HOLD.
- **Stepping rule.** Let d2 = (pos2==NOTCH_R2) and c1 = (pos1==NOTCH_R1), both evaluated on the pre-step values.
  - pos1 always advances by 1.
  - pos2 advances by 1 if d2 or c1.
  - pos3 advances by 1 if d2.
  - Each rotor advances at most once per character, even when d2 and c1 are both true.
  - All increments are mod 26: 25→0.
- **HOLD:** out_valid=1. out_char and pos1..3 are held stable. When out_ready=1 is sampled on an edge, out_valid clears to 0 and the state returns to IDLE.
- load, char_valid and init_pos are ignored in STEP and HOLD.
- Positions change only on load or in STEP. During IDLE they remain visible to the rotors.

## Timing
- **Reset (async, immediate):**
  - state=IDLE
  - pos1=pos2=pos3=0
  - out_char=0
  - out_valid=0
  - char_count=0
  - char_ready follows IDLE, so it is 1 unless load is asserted.
- **Latency:** acceptance on edge N. State is STEP during cycle N..N+1. On edge N+1 the positions update and out_valid rises.
- **Handshake:**
  - out_valid stays high for at least 1 cycle, until out_ready is sampled high.
  - out_ready may be held high permanently.
  - char_ready returns on edge N+2 at the earliest.
- **Throughput:** at most 1 character per 3 cycles.
- **Downstream timing:** rotor stages are combinational on pos and out_char, so downstream may sample at any cycle where out_valid=1.
- **Reset asserted mid-STEP or mid-HOLD:** the pending character is discarded, there is no out_valid pulse, and positions return to 0.

## Test plan
- **Reset:** assert rst mid-HOLD -> out_valid=0, pos=(0,0,0), char_count=0, char_ready=1 immediately, without waiting for a clock edge.
- **Load and range fold:** load with init (pos3,pos2,pos1)=(0,3,15), then char_in=0 with char_valid -> out_valid on the second edge after acceptance. Positions (0,3,16), out_char=0, char_count=1. Also load init_pos1=30 -> pos1=4.
- **Double-step:** from (0,3,16), three characters -> (0,4,17), then (1,5,18), then (1,5,19).
- **Wrap:**
  - (25,25,25) + 1 character -> (25,25,0).
  - (25,4,0) + 1 character -> (0,5,1).
- **Simultaneous carry:** (2,4,16) + 1 character -> (3,5,17), with pos2 advanced only once.
- **Handshake stall and priority:**
  - Hold out_ready=0 for 5 cycles with char_valid=1 -> out_valid stays 1, pos and out_char are stable, char_ready=0.
  - Assert load and char_valid together in IDLE -> char_ready=0, load applied, character not accepted.
